// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: arcade ghost scatter/chase/fright mode timer with wave and release sequencing
module ghost_mode_scheduler #(
    parameter int HOLD_SECS    = 3,
    parameter int SCATTER_SECS = 7,
    parameter int CHASE_SECS   = 20,
    parameter int FRIGHT_SECS  = 6,
    parameter int FLASH_SECS   = 2,
    parameter int NUM_WAVES    = 4,
    parameter int RELEASE_SECS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec,
    input  logic       power_pellet,
    input  logic       life_down,
    input  logic       restart,
    output logic [1:0] mode,
    output logic       reverse,
    output logic [3:0] released,
    output logic       fright_flash,
    output logic [2:0] wave,
    output logic [4:0] secs_left
);
    typedef enum logic [1:0] {HOLD, SCATTER, CHASE, FRIGHT} state_t;
    localparam logic [4:0] SC_LATE = SCATTER_SECS > 3 ? 5'(SCATTER_SECS - 2) : 5'd1;
    state_t     state, saved_state;
    logic [4:0] saved_secs, rel_cnt, scatter_len, next_scatter_len, chase_len;
    logic       final_wave, rel_step;
    assign final_wave       = wave == 3'(NUM_WAVES - 1);
    assign scatter_len      = wave < 3'd2 ? 5'(SCATTER_SECS) : SC_LATE;
    assign next_scatter_len = wave < 3'd1 ? 5'(SCATTER_SECS) : SC_LATE;
    assign chase_len        = final_wave ? 5'd0 : 5'(CHASE_SECS);
    assign rel_step         = !released[3] && rel_cnt == 5'(RELEASE_SECS - 1);
    assign mode             = state;
    assign fright_flash     = state == FRIGHT && secs_left <= 5'(FLASH_SECS);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            secs_left   <= 5'(HOLD_SECS);
            wave        <= 3'd0;
            released    <= 4'd0;
            reverse     <= 1'b0;
            rel_cnt     <= 5'd0;
            saved_state <= HOLD;
            saved_secs  <= 5'd0;
        end else begin
            reverse <= 1'b0;
            if (restart || life_down) begin
                state       <= HOLD;
                secs_left   <= 5'(HOLD_SECS);
                released    <= 4'd0;
                rel_cnt     <= 5'd0;
                saved_state <= HOLD;
                saved_secs  <= 5'd0;
                if (restart) wave <= 3'd0;
            end else if (power_pellet && state != HOLD) begin
                // a re-eaten pellet only refreshes the timer; the first one saves the wave context
                if (state != FRIGHT) begin
                    saved_state <= state;
                    saved_secs  <= secs_left;
                    reverse     <= 1'b1;
                end
                state     <= FRIGHT;
                secs_left <= 5'(FRIGHT_SECS);
            end else if (sec) begin
                if (state != HOLD && !released[3]) begin
                    released <= rel_step ? {released[2:0], 1'b1} : released;
                    rel_cnt  <= rel_step ? 5'd0 : rel_cnt + 5'd1;
                end
                if (secs_left == 5'd1) begin
                    case (state)
                        HOLD: begin
                            state     <= SCATTER;
                            secs_left <= scatter_len;
                            released  <= 4'b0001;
                            rel_cnt   <= 5'd0;
                        end
                        SCATTER: begin
                            state     <= CHASE;
                            secs_left <= chase_len;
                            reverse   <= 1'b1;
                        end
                        CHASE: begin
                            state     <= SCATTER;
                            secs_left <= next_scatter_len;
                            wave      <= wave + 3'd1;
                            reverse   <= 1'b1;
                        end
                        default: begin
                            state     <= saved_state;
                            secs_left <= saved_secs;
                        end
                    endcase
                end else if (secs_left != 5'd0) begin
                    secs_left <= secs_left - 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: directed and randomized checks against a behavioural game-rule model
module tb_ghost_mode_scheduler;
    localparam int H = 1, SC = 2, C = 3, F = 4, FL = 1, NW = 2, R = 1;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sec = 1'b0, power_pellet = 1'b0, life_down = 1'b0, restart = 1'b0;
    logic [1:0] mode;
    logic       reverse, fright_flash;
    logic [3:0] released;
    logic [2:0] wave;
    logic [4:0] secs_left;
    int n_cmp = 0, n_bad = 0;
    int m_mode, m_secs, m_wave, m_nrel, m_rcnt, m_smode, m_ssecs, m_rev;

    ghost_mode_scheduler #(.HOLD_SECS(H), .SCATTER_SECS(SC), .CHASE_SECS(C), .FRIGHT_SECS(F),
        .FLASH_SECS(FL), .NUM_WAVES(NW), .RELEASE_SECS(R)) dut (
        .clk(clk), .rst_n(rst_n), .sec(sec), .power_pellet(power_pellet), .life_down(life_down),
        .restart(restart), .mode(mode), .reverse(reverse), .released(released),
        .fright_flash(fright_flash), .wave(wave), .secs_left(secs_left));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scat(input int w);
        return w < 2 ? SC : (SC - 2 > 1 ? SC - 2 : 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_secs = H; m_wave = 0; m_nrel = 0; m_rcnt = 0; m_smode = 0; m_ssecs = 0; m_rev = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit l, input bit r);
        m_rev = 0;
        if (r || l) begin
            if (r) m_wave = 0;
            m_mode = 0; m_secs = H; m_nrel = 0; m_rcnt = 0; m_smode = 0; m_ssecs = 0;
        end else if (p && m_mode != 0) begin
            if (m_mode != 3) begin m_smode = m_mode; m_ssecs = m_secs; m_rev = 1; end
            m_mode = 3; m_secs = F;
        end else if (s) begin
            if (m_mode == 0) begin
                if (m_secs > 1) m_secs--;
                else begin m_mode = 1; m_secs = scat(m_wave); m_nrel = 1; m_rcnt = 0; end
            end else begin
                if (m_nrel < 4) begin
                    m_rcnt++;
                    if (m_rcnt == R) begin m_nrel++; m_rcnt = 0; end
                end
                if (m_mode == 2 && m_wave == NW - 1) ;
                else if (m_secs > 1) m_secs--;
                else if (m_mode == 1) begin m_mode = 2; m_secs = (m_wave == NW - 1) ? 0 : C; m_rev = 1; end
                else if (m_mode == 2) begin m_wave++; m_mode = 1; m_secs = scat(m_wave); m_rev = 1; end
                else begin m_mode = m_smode; m_secs = m_ssecs; end
            end
        end
    endtask

    task automatic compare_all();
        check("mode", int'(mode), m_mode);
        check("secs_left", int'(secs_left), m_secs);
        check("wave", int'(wave), m_wave);
        check("release", int'(released), (1 << m_nrel) - 1);
        check("reverse", int'(reverse), m_rev);
        check("fright_flash", int'(fright_flash), int'(m_mode == 3 && m_secs <= FL));
    endtask

    task automatic cyc(input bit s, input bit p, input bit l, input bit r);
        sec = s; power_pellet = p; life_down = l; restart = r;
        @(posedge clk);
        model_step(s, p, l, r);
        #1;
        compare_all();
        sec = 1'b0; power_pellet = 1'b0; life_down = 1'b0; restart = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mode"}, int'(mode), 0);
        check({tag, "_secs"}, int'(secs_left), H);
        check({tag, "_wave"}, int'(wave), 0);
        check({tag, "_release"}, int'(released), 0);
        check({tag, "_reverse"}, int'(reverse), 0);
        check({tag, "_flash"}, int'(fright_flash), 0);
    endtask

    initial begin
        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
        cyc(1, 0, 0, 0);
        check("first_scatter_mode", int'(mode), 1);
        check("first_scatter_secs", int'(secs_left), 2);
        check("first_release", int'(released), 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("first_chase_mode", int'(mode), 2);
        check("first_chase_reverse", int'(reverse), 1);
        check("release_three", int'(released), 7);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
        check("final_chase_mode", int'(mode), 2);
        check("final_chase_secs", int'(secs_left), 0);
        check("final_chase_wave", int'(wave), 1);
        cyc(0, 1, 0, 0);
        check("pellet_final_mode", int'(mode), 3);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check("fright_back_to_final", int'(mode), 2);
        cyc(0, 0, 1, 0);
        check("lifedown_wave_kept", int'(wave), 1);
        cyc(0, 0, 1, 1);
        check("restart_with_lifedown_wave", int'(wave), 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("pellet_scatter_secs", int'(secs_left), F);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check("flash_on", int'(fright_flash), 1);
        cyc(1, 1, 0, 0);
        check("pellet_beats_sec", int'(secs_left), F);
        cyc(1, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 40, $urandom_range(99) < 4,
                $urandom_range(199) == 0, $urandom_range(299) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ghost_mode_scheduler.md
GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

Interface
REQ-001 Parameter HOLD_SECS, default 3: seconds in HOLD before play begins; must be at least 1.
REQ-002 Parameter SCATTER_SECS, default 7: scatter duration for waves 0-1; waves 2 and later use SCATTER_SECS-2, with a floor of 1.
REQ-003 Parameter CHASE_SECS, default 20: chase duration; must be at least 1.
REQ-004 Parameter FRIGHT_SECS, default 6: fright duration; must be at least 1.
REQ-005 Parameter FLASH_SECS, default 2: length of the fright-ending flash window; must be at most FRIGHT_SECS.
REQ-006 Parameter NUM_WAVES, default 4: number of timed scatter/chase waves; the chase of wave NUM_WAVES-1 never expires.
REQ-007 Parameter RELEASE_SECS, default 4: seconds between successive ghost releases.
REQ-008 Clk  in  1  system clock; all state changes on the rising edge.
REQ-009 Reset  in  1  asynchronous, active-low reset.
REQ-010 sec  in  1  one-Clk pulse once per second.
REQ-011 power_pellet  in  1  one-Clk pulse when Pac-Man eats an energizer.
REQ-012 lifeDown  in  1  one-Clk pulse when a life is lost.
REQ-013 restart  in  1  one-Clk pulse to start a new game.
REQ-014 mode  out  2  00 HOLD, 01 SCATTER, 10 CHASE, 11 FRIGHT.
REQ-015 reverse  out  1  one-Clk pulse commanding all ghosts to reverse direction.
REQ-016 release  out  4  per-ghost release bits; bit0 is red, bits 1-3 are the other ghosts; a set bit stays set.
REQ-017 fright_flash  out  1  high while in FRIGHT and secs_left <= FLASH_SECS.
REQ-018 wave  out  3  current wave index; saturates at NUM_WAVES-1.
REQ-019 secs_left  out  5  seconds remaining in the current timed state; 0 for untimed final chase.

Function
REQ-020 The state machine SHALL have states HOLD, SCATTER, CHASE and FRIGHT, all registered; outputs change one Clk after the causing input pulse.
REQ-021 State timing SHALL work as follows.
- secs_left loads the state duration on entry.
- Each sec pulse decrements it.
- A sec pulse seen while secs_left==1 causes the transition, so each state lasts exactly N sec pulses.
REQ-022 Normal transitions SHALL be:
- HOLD -> SCATTER on timer expiry.
- SCATTER -> CHASE on expiry.
- CHASE -> SCATTER on expiry, with wave incremented; not taken when wave==NUM_WAVES-1.
REQ-023 A power_pellet pulse in SCATTER or CHASE SHALL:
- save the current mode and its secs_left;
- enter FRIGHT with secs_left=FRIGHT_SECS.
The wave timer is frozen during FRIGHT.
REQ-024 A power_pellet pulse in FRIGHT SHALL reload secs_left to FRIGHT_SECS and leave the saved context unchanged.
REQ-025 A power_pellet pulse in HOLD SHALL be ignored.
REQ-026 On FRIGHT expiry the block SHALL return to the saved mode with the saved secs_left restored unchanged.
REQ-027 reverse SHALL pulse for exactly one Clk on the following events, and on no other transition:
- SCATTER -> CHASE;
- CHASE -> SCATTER;
- entry into FRIGHT from SCATTER or CHASE.
REQ-028 Ghost release SHALL work as follows.
- release[0] is set on HOLD exit.
- A release counter then sets release[1], [2] and [3] in turn, each RELEASE_SECS sec pulses after the previous bit.
- The release counter keeps running during FRIGHT.
REQ-029 On a lifeDown pulse the block SHALL:
- enter HOLD with secs_left=HOLD_SECS;
- clear release and the release counter;
- clear the saved FRIGHT context;
- keep wave unchanged.
On HOLD exit, SCATTER restarts with that wave's full duration.
REQ-030 A restart pulse SHALL act like lifeDown and additionally clear wave to 0.
REQ-031 Simultaneous-event priority SHALL be restart, then lifeDown, then power_pellet, then sec.
- A sec pulse coinciding with any higher-priority event is not counted.
- A release step due on that sec pulse is also dropped.
REQ-032 In the final chase (wave==NUM_WAVES-1), secs_left SHALL be 0 and sec pulses SHALL NOT cause transitions; FRIGHT still interrupts and returns to it.
REQ-033 fright_flash SHALL be combinational from the registered mode and secs_left, and SHALL be low outside FRIGHT.

Reset
REQ-034 While Reset is low, the block SHALL hold:
- mode=HOLD, secs_left=HOLD_SECS;
- wave=0, release=0000;
- reverse=0, fright_flash=0;
- release counter and saved context cleared.
REQ-035 After Reset deasserts, the block SHALL begin counting sec pulses on the first rising Clk edge.
REQ-036 Reset assertion mid-FRIGHT or mid-wave SHALL take effect immediately (asynchronously) and discard all progress.

Verification
Parameters for all scenarios: HOLD=1, SCATTER=2, CHASE=3, FRIGHT=4, FLASH=1, NUM_WAVES=2, RELEASE=1.
- Reset then 1 sec -> mode=01, secs_left=2, release=0001, reverse=0. After 2 more sec -> mode=10, reverse pulsed once, release=0111.
- 6 further sec -> CHASE->SCATTER with wave=1, then SCATTER->CHASE; then 10 sec -> mode stays 10, secs_left=0, no reverse.
- In SCATTER with secs_left=1: power_pellet -> mode=11, reverse pulse, secs_left=4. After 3 sec -> fright_flash=1. After 1 more sec -> mode=01, secs_left=1, no reverse.
- In FRIGHT with secs_left=2: power_pellet -> secs_left=4. power_pellet and sec in the same cycle -> pellet wins, secs_left=4.
- lifeDown in CHASE of wave 1 -> mode=00, release=0000, wave=1. restart -> wave=0. restart and lifeDown together -> wave=0.
- Reset pulsed low mid-FRIGHT -> all outputs return to reset values with no Clk edge required.
